// File: rtl/or1200_sstk_chk_if.sv
// Shadow-stack checker bus: decode/EX-side inputs and status/capture outputs.
// master drives instruction/operand/control; slave (the checker) drives status.
interface or1200_sstk_chk_if #(
    parameter int AW = 6
);
    logic [31:0] id_insn;
    logic [31:0] id_pc;
    logic        ex_freeze;
    logic [31:0] operand_b;
    logic        sstk_flush;
    logic        sstk_ack;

    logic [AW:0] sstk_count;
    logic        sstk_mismatch;
    logic        sstk_ovf;
    logic        sstk_unf;
    logic [31:0] sstk_err_pc;
    logic [31:0] sstk_err_exp;
    logic [31:0] sstk_err_act;
    logic        sstk_except;

    modport master (
        output id_insn, id_pc, ex_freeze, operand_b, sstk_flush, sstk_ack,
        input  sstk_count, sstk_mismatch, sstk_ovf, sstk_unf,
        input  sstk_err_pc, sstk_err_exp, sstk_err_act, sstk_except
    );

    modport slave (
        input  id_insn, id_pc, ex_freeze, operand_b, sstk_flush, sstk_ack,
        output sstk_count, sstk_mismatch, sstk_ovf, sstk_unf,
        output sstk_err_pc, sstk_err_exp, sstk_err_act, sstk_except
    );
endinterface

// File: rtl/or1200_sstk_chk.sv
// Shadow stack + return-address checker; push/pop visible 1 cycle after edge, mismatch 2 edges after pop.
// No backpressure: ex_freeze stalls push/pop/check; optional sticky exception via OR1200_SSTK_EXCEPT_EN.
// Full stack overwrites the oldest entry (sstk_ovf); pop on empty flags sstk_unf.
module or1200_sstk_chk #(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int LR_IDX = 9
) (
    input  logic               clk,
    input  logic               rst,
    or1200_sstk_chk_if.slave   bus
);

    localparam logic [5:0] OPC_JAL  = 6'h01;
    localparam logic [5:0] OPC_JR   = 6'h11;
    localparam logic [5:0] OPC_JALR = 6'h12;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [4:0]    LR_REG   = 5'(LR_IDX);

    // storage and pointers
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW:0]   count;

    // pending return check
    logic          chk_pend;
    logic [31:0]   exp_q;
    logic [31:0]   pc_q;

    // registered status
    logic          mismatch_q;
    logic          ovf_q;
    logic          unf_q;
    logic [31:0]   err_pc_q;
    logic [31:0]   err_exp_q;
    logic [31:0]   err_act_q;

    // decode
    logic [5:0]    opcode;
    logic [4:0]    rb_idx;
    logic          is_push;
    logic          is_pop;
    logic          do_check;
    logic          chk_miss;
    logic [AW-1:0] top_idx;
    logic [31:0]   link_val;
    logic          full;
    logic          empty;

    assign opcode   = bus.id_insn[31:26];
    assign rb_idx   = bus.id_insn[15:11];
    assign is_push  = !bus.ex_freeze && ((opcode == OPC_JAL) || (opcode == OPC_JALR));
    assign is_pop   = !bus.ex_freeze && (opcode == OPC_JR) && (rb_idx == LR_REG);
    assign do_check = chk_pend && !bus.ex_freeze && !bus.sstk_flush;
    assign chk_miss = do_check && (bus.operand_b != exp_q);
    assign top_idx  = wptr - PTR_ONE;
    assign link_val = bus.id_pc + 32'd8;
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);

    // Storage has no reset; entries are only read below the valid count.
    always_ff @(posedge clk) begin
        if (!bus.sstk_flush && is_push) begin
            mem[wptr] <= link_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            count      <= '0;
            chk_pend   <= 1'b0;
            exp_q      <= '0;
            pc_q       <= '0;
            mismatch_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            err_pc_q   <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else begin
            mismatch_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;

            if (bus.sstk_flush) begin
                wptr     <= '0;
                count    <= '0;
                chk_pend <= 1'b0;
            end else begin
                // The check consumes the old exp_q; a same-edge pop may re-arm below.
                if (do_check) begin
                    chk_pend <= 1'b0;
                    if (chk_miss) begin
                        mismatch_q <= 1'b1;
                        err_pc_q   <= pc_q;
                        err_exp_q  <= exp_q;
                        err_act_q  <= bus.operand_b;
                    end
                end

                if (is_push) begin
                    wptr <= wptr + PTR_ONE;
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end else if (is_pop) begin
                    if (empty) begin
                        unf_q <= 1'b1;
                    end else begin
                        exp_q    <= mem[top_idx];
                        pc_q     <= bus.id_pc;
                        chk_pend <= 1'b1;
                        wptr     <= top_idx;
                        count    <= count - CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef OR1200_SSTK_EXCEPT_EN
    logic except_q;

    // Acknowledge wins over a mismatch landing on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            except_q <= 1'b0;
        end else if (bus.sstk_ack) begin
            except_q <= 1'b0;
        end else if (chk_miss) begin
            except_q <= 1'b1;
        end
    end

    assign bus.sstk_except = except_q;
`else
    assign bus.sstk_except = 1'b0;
`endif

    assign bus.sstk_count    = count;
    assign bus.sstk_mismatch = mismatch_q;
    assign bus.sstk_ovf      = ovf_q;
    assign bus.sstk_unf      = unf_q;
    assign bus.sstk_err_pc   = err_pc_q;
    assign bus.sstk_err_exp  = err_exp_q;
    assign bus.sstk_err_act  = err_act_q;

endmodule

// File: tb/tb_or1200_sstk_chk.sv
// Directed + randomized bench for or1200_sstk_chk against a queue-based return-stack model.
module tb_or1200_sstk_chk;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int LR    = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    or1200_sstk_chk_if #(.AW(AW)) sif ();

    or1200_sstk_chk #(.DEPTH(DEPTH), .AW(AW), .LR_IDX(LR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] q[$];
    logic        pend  = 1'b0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_pc  = '0;
    logic        e_mm  = 1'b0, e_ovf = 1'b0, e_unf = 1'b0, e_exc = 1'b0;
    logic [31:0] e_pc  = '0, e_exp = '0, e_act = '0;

    localparam logic [31:0] NOP = 32'h1500_0000;

    function automatic logic [31:0] jal();
        return {6'h01, 26'($urandom)};
    endfunction
    function automatic logic [31:0] jalr(input logic [4:0] rb);
        return {6'h12, 10'h0, rb, 11'h0};
    endfunction
    function automatic logic [31:0] jr(input logic [4:0] rb);
        return {6'h11, 10'h0, rb, 11'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string s);
        chk({s, ".count"},    32'(sif.sstk_count), 32'(q.size()));
        chk({s, ".mismatch"}, 32'(sif.sstk_mismatch), 32'(e_mm));
        chk({s, ".ovf"},      32'(sif.sstk_ovf), 32'(e_ovf));
        chk({s, ".unf"},      32'(sif.sstk_unf), 32'(e_unf));
        chk({s, ".err_pc"},   sif.sstk_err_pc, e_pc);
        chk({s, ".err_exp"},  sif.sstk_err_exp, e_exp);
        chk({s, ".err_act"},  sif.sstk_err_act, e_act);
        chk({s, ".except"},   32'(sif.sstk_except), 32'(e_exc));
    endtask

    task automatic model_reset();
        q.delete();
        pend = 1'b0;
        e_mm = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_exc = 1'b0;
        e_pc = '0; e_exp = '0; e_act = '0;
    endtask

    // Abstract behaviour: a bounded LIFO that drops its oldest element when full.
    task automatic model_edge(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] opb,
                              input logic frz, input logic fl, input logic ack);
        logic [5:0] opc;
        opc   = insn[31:26];
        e_mm  = 1'b0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (fl) begin
            q.delete();
            pend = 1'b0;
        end else if (!frz) begin
            if (pend) begin
                pend = 1'b0;
                if (opb !== m_exp) begin
                    e_mm = 1'b1; e_pc = m_pc; e_exp = m_exp; e_act = opb;
                end
            end
            if (opc == 6'h01 || opc == 6'h12) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    e_ovf = 1'b1;
                end
                q.push_back(pc + 32'd8);
            end else if (opc == 6'h11 && insn[15:11] == 5'(LR)) begin
                if (q.size() == 0) begin
                    e_unf = 1'b1;
                end else begin
                    m_exp = q.pop_back();
                    m_pc  = pc;
                    pend  = 1'b1;
                end
            end
        end
`ifdef OR1200_SSTK_EXCEPT_EN
        if (ack)       e_exc = 1'b0;
        else if (e_mm) e_exc = 1'b1;
`else
        e_exc = 1'b0;
`endif
    endtask

    task automatic step(input string tag, input logic [31:0] insn, input logic [31:0] pc,
                        input logic [31:0] opb, input logic frz = 1'b0,
                        input logic fl = 1'b0, input logic ack = 1'b0);
        sif.id_insn    = insn;
        sif.id_pc      = pc;
        sif.operand_b  = opb;
        sif.ex_freeze  = frz;
        sif.sstk_flush = fl;
        sif.sstk_ack   = ack;
        model_edge(insn, pc, opb, frz, fl, ack);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        sif.id_insn = NOP; sif.id_pc = '0; sif.operand_b = '0;
        sif.ex_freeze = 1'b0; sif.sstk_flush = 1'b0; sif.sstk_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // matching return
        step("m_jal",   jal(),   32'h100, 32'h0);
        step("m_jr",    jr(5'd9), 32'h104, 32'h0);
        step("m_chk",   NOP,     32'h108, 32'h108);

        // mismatching return, then acknowledge
        step("x_jal",   jal(),   32'h100, 32'h0);
        step("x_jr",    jr(5'd9), 32'h300, 32'h0);
        step("x_chk",   NOP,     32'h304, 32'h200);
        step("x_hold",  NOP,     32'h308, 32'h0);
        step("x_ack",   NOP,     32'h30c, 32'h0, 1'b0, 1'b0, 1'b1);
        step("x_post",  NOP,     32'h310, 32'h0);

        // overflow at depth 4, then five returns
        for (int i = 0; i < 5; i++)
            step("o_push", (i % 2) ? jalr(5'd4) : jal(), 32'(i * 16), 32'h0);
        step("o_pop1", jr(5'd9), 32'h500, 32'h0);
        step("o_pop2", jr(5'd9), 32'h504, 32'h48);
        step("o_pop3", jr(5'd9), 32'h508, 32'h38);
        step("o_pop4", jr(5'd9), 32'h50c, 32'h28);
        step("o_unf",  jr(5'd9), 32'h510, 32'h18);

        // empty-stack returns
        step("e_jr9",  jr(5'd9), 32'h600, 32'h0);
        step("e_jr3",  jr(5'd3), 32'h604, 32'h0);

        // frozen check
        step("f_jal",  jal(),    32'h700, 32'h0);
        step("f_jr",   jr(5'd9), 32'h800, 32'h0);
        for (int i = 0; i < 3; i++)
            step("f_frz", jal(), 32'h900, 32'hdead, 1'b1);
        step("f_chk",  NOP,      32'h904, 32'hdead);
        step("f_post", NOP,      32'h908, 32'h0);

        // flush on the same edge as a pop
        step("l_jal",  jal(),    32'ha00, 32'h0);
        step("l_fl",   jr(5'd9), 32'hb00, 32'h0, 1'b0, 1'b1);
        step("l_post", NOP,      32'hb04, 32'hbad);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] insn, pc, opb;
            int sel;
            sel  = $urandom_range(0, 9);
            insn = (sel < 3) ? jal() : (sel < 4) ? jalr(5'($urandom)) :
                   (sel < 7) ? jr(5'd9) : (sel < 8) ? jr(5'($urandom)) : NOP;
            pc   = ($urandom_range(0, 15) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
            opb  = (pend && $urandom_range(0, 1)) ? m_exp : $urandom;
            step("rand", insn, pc, opb, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
        end

        // reset while a check is pending aborts it
        step("r_jal",  jal(),    32'hc00, 32'h0);
        step("r_jr",   jr(5'd9), 32'hd00, 32'h0);
        sif.operand_b = 32'h1234;
        rst = 1'b0;
        model_reset();
        #2;
        check_all("r_mid");
        @(negedge clk);
        rst = 1'b1;
        step("r_post", NOP, 32'hd04, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/or1200_sstk_chk.md
# or1200_sstk_chk

Parametrised hardware shadow stack and return-address checker for the OR1200 core. It sits beside the ID/EX boundary. It pushes the link value of every `l.jal`/`l.jalr` into a configurable-depth circular buffer and pops it on `l.jr r9`. It compares the popped value with the register operand the return actually uses. Mismatch, overflow and underflow are reported as registered status pulses and a capture record, with an optional sticky exception request towards the exception unit.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit entries; power of two, 4..1024
- AW, 6, pointer width; must equal log2(DEPTH)
- LR_IDX, 9, register index treated as the link register on `l.jr`

Ports:
- clk  in  1  core clock; everything on rising edge
- rst  in  1  asynchronous, active-low reset
- id_insn  in  32  instruction in decode stage
- id_pc  in  32  PC of id_insn
- ex_freeze  in  1  EX stage frozen; no push, pop or check while high
- operand_b  in  32  EX-stage source-register value (jump target of the `l.jr` in EX)
- sstk_flush  in  1  discard all entries and any pending check (context switch / exception entry)
- sstk_count  out  AW+1  valid entries held, 0..DEPTH
- sstk_mismatch  out  1  one-cycle pulse: checked return address differed
- sstk_ovf  out  1  one-cycle pulse: push onto full stack overwrote oldest entry
- sstk_unf  out  1  one-cycle pulse: pop from empty stack, check skipped
- sstk_err_pc  out  32  PC of the `l.jr` of the most recent mismatch
- sstk_err_exp  out  32  expected (shadow) address of the most recent mismatch
- sstk_err_act  out  32  actual operand_b of the most recent mismatch
- sstk_except  out  1  sticky exception request (see Configuration)
- sstk_ack  in  1  clears sstk_except

## Operation
- Decode, qualified by !ex_freeze:
  - push on opcode JAL or JALR;
  - pop on opcode JR with id_insn[15:11] == LR_IDX;
  - anything else is idle.
- Push: writes id_pc + 8 at wptr (the link value, accounting for the delay slot). Then wptr <= wptr+1 modulo DEPTH.
  - count < DEPTH: count+1.
  - count == DEPTH: count stays DEPTH; the oldest entry is lost and sstk_ovf pulses.
- Pop, count > 0: exp_q <= entry[wptr-1], pc_q <= id_pc, chk_pend <= 1, wptr-1, count-1.
- Pop, count == 0: sstk_unf pulses. No check is armed and the pointers are unchanged.
- Check: at the first clock edge with chk_pend==1 and !ex_freeze, operand_b is compared to exp_q and chk_pend clears.
  - Unequal: sstk_mismatch pulses, and sstk_err_pc/exp/act load pc_q/exp_q/operand_b.
  - Equal: no output activity.
- Same-edge events:
  - A check and a new push or pop on the same edge are both performed. A new pop re-arms chk_pend with the new values.
  - sstk_flush has priority over everything: wptr <= 0, count <= 0, chk_pend <= 0, and no pulse is generated on that edge. Capture registers and sstk_except are untouched.
  - sstk_ack has priority over a new setting of sstk_except on the same edge.
- Arithmetic: pointer arithmetic wraps modulo DEPTH. id_pc+8 wraps modulo 2^32.
- Reset values: every output is 0 and the internal state is wptr=0, count=0, chk_pend=0. Storage contents are don't-care. Reset asserted mid-operation aborts any pending check silently.

## Timing
- Push/pop at edge E: sstk_count reflects it after E.
- Pulses (sstk_ovf, sstk_unf, sstk_mismatch) are registered, high for exactly one cycle after the causing edge.
- Mismatch latency: pop at edge E and check at edge E+1 if not frozen. sstk_mismatch is high in the cycle after E+1. Each frozen cycle adds one.
- sstk_except rises in the same cycle as sstk_mismatch.

## Configuration
- Macro OR1200_SSTK_EXCEPT_EN.
- Defined: sstk_except sets on each mismatch and stays high until an edge with sstk_ack==1.
- Undefined: sstk_except is tied 0, sstk_ack is ignored, and the exception logic is not synthesised; status outputs behave identically.

## Test plan
- Reset with rst=0 then release: all outputs 0, sstk_count=0.
- JAL at id_pc=0x100, then `l.jr r9` with operand_b=0x108: count 1 then 0, no sstk_mismatch.
- JAL at 0x100, then `l.jr r9` with operand_b=0x200: sstk_mismatch pulse; err_pc = PC of the jr, err_exp=0x108, err_act=0x200; sstk_except high until sstk_ack (macro defined), stays 0 (macro undefined).
- DEPTH=4, JALs at 0x0,0x10,0x20,0x30,0x40: sstk_ovf on the 5th push, count stays 4. Five returns with matching operands: the first four checks pass (0x48,0x38,0x28,0x18) and the fifth pop raises sstk_unf.
- `l.jr r9` on an empty stack: sstk_unf pulse, count 0, no mismatch. `l.jr r3`: no pop, no status.
- Pop followed by ex_freeze high for 3 cycles with a wrong operand_b, then unfrozen: mismatch appears exactly 1 cycle after the first unfrozen edge. A second case asserts sstk_flush on the same edge as a pop: count=0, no pulse, no check.
